uram_write: RTL

- Fills a URAM region with a block of WIDTH-bit words popped from a standard (non-FWFT) FIFO.
- A `start` pulse supplies a base address and a word count. The block streams words from the FIFO into consecutive URAM addresses, then pulses `done`.
- It is the write-side counterpart of the URAM-to-FIFO reader in the modular-exponentiation precompute path: it loads precomputed operand tables into URAM before the reader consumes them.

---
 rtl/uram_pkg.sv | 14 +
 rtl/uram_addr_cnt.sv | 31 +++
 rtl/uram_write.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uram_pkg.sv
// uram_pkg: shared types and default sizes for the URAM reader/writer pair.
// No ports; holds the FSM state enum and default WIDTH/URAM_ADDR constants.
package uram_pkg;

  localparam int WIDTH_DEF     = 3072;
  localparam int URAM_ADDR_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/uram_addr_cnt.sv
// uram_addr_cnt: loadable URAM address counter, wraps modulo 2^AW.
// Ports: clk, rst (sync, active-high), load/load_val, inc, addr.
module uram_addr_cnt
  import uram_pkg::*;
#(
  parameter int AW = URAM_ADDR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] addr_q;

  // Load wins over increment; wrap is the natural AW-bit overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= load_val;
    end else if (inc) begin
      addr_q <= addr_q + AW'(1);
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/uram_write.sv
// uram_write: streams num_words words from a non-FWFT FIFO into URAM
// starting at base_addr, one word per cycle, then pulses done.
// Ports: clk, rst (sync, active-high), start/base_addr/num_words request,
//   busy/done status, rempty/data_fifo/read_fifo FIFO side,
//   data_uram/wr_uram/wr_addr URAM side.
// Optional: define URAM_WRITE_CHK_EN to add chk, the XOR of all words
//   written in the current transfer.
module uram_write
  import uram_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int URAM_ADDR = URAM_ADDR_DEF,
  parameter int CNT_W     = URAM_ADDR + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [URAM_ADDR-1:0] base_addr,
  input  logic [CNT_W-1:0]     num_words,
  output logic                 busy,
  output logic                 done,
  input  logic                 rempty,
  input  logic [WIDTH-1:0]     data_fifo,
  output logic                 read_fifo,
  output logic [WIDTH-1:0]     data_uram,
  output logic                 wr_uram,
  output logic [URAM_ADDR-1:0] wr_addr
`ifdef URAM_WRITE_CHK_EN
  ,
  output logic [WIDTH-1:0]     chk
`endif
);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     num_q;
  logic [CNT_W-1:0]     issued_q;
  logic [CNT_W-1:0]     written_q;
  logic                 rd_v_q;
  logic [URAM_ADDR-1:0] addr_q;
  logic                 accept;
  logic                 pop;
  logic                 last_wr;

  assign accept = (state_q == IDLE) && start;

  // Pop only while words remain to be requested and the FIFO has data.
  assign pop = (state_q == RUN) && !rempty
             && (issued_q != num_q);

  // A write lands the cycle after its pop; this is the final one.
  assign last_wr = rd_v_q
                 && ((written_q + CNT_W'(1)) == num_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_wr) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    read_fifo = pop;
    wr_uram   = rd_v_q;
    wr_addr   = addr_q;
    // FIFO data goes straight to URAM; zeroed when idle.
    data_uram = rd_v_q ? data_fifo : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q     <= '0;
      issued_q  <= '0;
      written_q <= '0;
      rd_v_q    <= 1'b0;
    end else begin
      rd_v_q <= pop;
      if (accept) begin
        num_q     <= num_words;
        issued_q  <= '0;
        written_q <= '0;
      end else begin
        if (pop) begin
          issued_q <= issued_q + CNT_W'(1);
        end
        if (rd_v_q) begin
          written_q <= written_q + CNT_W'(1);
        end
      end
    end
  end

  uram_addr_cnt #(
    .AW(URAM_ADDR)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .load_val(base_addr),
    .inc     (rd_v_q),
    .addr    (addr_q)
  );

`ifdef URAM_WRITE_CHK_EN
  logic [WIDTH-1:0] chk_q;

  // Holds its value after done until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= '0;
    end else if (accept) begin
      chk_q <= '0;
    end else if (rd_v_q) begin
      chk_q <= chk_q ^ data_fifo;
    end
  end

  assign chk = chk_q;
`endif

endmodule
